fft_stage_sequencer: RTL

- Control block for an in-place radix-2 DIT FFT engine of N points.
- On start, steps through all log2(N) stages and N/2 butterflies per stage. Each cycle it issues a twiddle ROM read address and the data-memory operand addresses for one butterfly.
- Delays the operand addresses and flags to line up with the twiddle ROM's fixed 2-cycle read latency.
- Inserts a programmable drain gap between stages so the butterfly pipeline finishes its write-back before the next stage reads.

---
 rtl/fft_stage_sequencer.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/fft_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stage_sequencer
// Description : Control sequencer for an in-place radix-2 DIT FFT engine.
//               Walks all log2(N) stages and N/2 butterflies per stage.
//               Each issue cycle it presents a twiddle ROM read address. The
//               matching data-memory operand addresses and flags appear
//               ROM_LATENCY cycles later, aligned with the ROM read data.
//               A programmable idle gap separates stages so the butterfly
//               pipeline can finish its write-back before the next stage.
// Ports       : clk, rst_n        - clock, synchronous active-low reset
//               start             - run one transform (sampled in IDLE only)
//               busy, done        - transform in progress / completion pulse
//               tw_addr           - twiddle ROM read address
//               issue_valid       - tw_addr carries a live butterfly
//               bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, bf_stage,
//               bf_last           - butterfly fields aligned to ROM data
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stage_sequencer #(
    parameter int N           = 16,
    parameter int BF_LATENCY  = 4,
    parameter int ROM_LATENCY = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(N)-1:0]        tw_addr,
    output logic                        issue_valid,
    output logic                        bf_valid,
    output logic [$clog2(N)-1:0]        bf_addr_a,
    output logic [$clog2(N)-1:0]        bf_addr_b,
    output logic [$clog2(N)-1:0]        bf_tw_addr,
    output logic [$clog2($clog2(N)):0]  bf_stage,
    output logic                        bf_last
);

    localparam int L  = $clog2(N);
    localparam int AW = L;
    localparam int SW = $clog2(L) + 1;
    localparam int KW = L - 1;
    localparam int GW = (BF_LATENCY > 0) ? $clog2(BF_LATENCY + 1) : 1;
    localparam int PW = 1 + 3 * AW + SW + 1;

    localparam logic [KW-1:0] K_LAST  = KW'(N / 2 - 1);
    localparam logic [SW-1:0] S_LAST  = SW'(L - 1);
    localparam logic [31:0]   GAP_LEN = 32'(BF_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_GAP   = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [KW-1:0]   k_q, k_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [PW-1:0]   pipe_q [ROM_LATENCY];
    logic [PW-1:0]   pipe_d [ROM_LATENCY];

    logic [AW-1:0]   w_k_ext;
    logic [AW-1:0]   w_half;
    logic [AW-1:0]   w_pos;
    logic [AW-1:0]   w_grp;
    logic [AW-1:0]   w_addr_a;
    logic [AW-1:0]   w_addr_b;
    logic [AW-1:0]   w_tw;
    logic            w_issue_last;
    logic [31:0]     w_gap_next;
    logic [PW-1:0]   w_entry;

    // Status and issue-side outputs decode from registered state only.
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign issue_valid = (state_q == S_ISSUE);
    assign tw_addr     = issue_valid ? w_tw : '0;

    // Butterfly address decode: k splits into a group index (upper bits)
    // and a position within the group (lower s bits).
    always_comb begin
        w_k_ext      = {1'b0, k_q};
        w_half       = AW'(1) << s_q;
        w_pos        = w_k_ext & (w_half - AW'(1));
        w_grp        = w_k_ext >> s_q;
        w_addr_a     = ((w_grp << s_q) << 1) + w_pos;
        w_addr_b     = w_addr_a + w_half;
        w_tw         = w_pos << (S_LAST - s_q);
        w_issue_last = issue_valid && (k_q == K_LAST) && (s_q == S_LAST);
    end

    // Alignment delay line; idle slots carry all-zero entries so the bf_*
    // outputs read zero whenever bf_valid is low.
    always_comb begin
        w_entry = '0;
        if (issue_valid) begin
            w_entry = {1'b1, w_addr_a, w_addr_b, w_tw, s_q, w_issue_last};
        end
        pipe_d[0] = w_entry;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign {bf_valid, bf_addr_a, bf_addr_b, bf_tw_addr, bf_stage, bf_last} =
        pipe_q[ROM_LATENCY-1];

    always_comb begin
        state_d    = state_q;
        s_d        = s_q;
        k_d        = k_q;
        gap_cnt_d  = gap_cnt_q;
        w_gap_next = 32'(gap_cnt_q) + 32'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_d     = '0;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (k_q == K_LAST) begin
                    k_d = '0;
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        state_d = S_FLUSH;
                    end else begin
                        s_d       = s_q + SW'(1);
                        gap_cnt_d = '0;
                        // With no drain gap the next stage issues back-to-back.
                        if (BF_LATENCY > 0) begin
                            state_d = S_GAP;
                        end
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_GAP: begin
                if (w_gap_next == GAP_LEN) begin
                    state_d = S_ISSUE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            S_FLUSH: begin
                // Hold until the final butterfly has left the delay line.
                if (bf_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            s_q       <= '0;
            k_q       <= '0;
            gap_cnt_q <= '0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            k_q       <= k_d;
            gap_cnt_q <= gap_cnt_d;
            pipe_q    <= pipe_d;
        end
    end

endmodule
`default_nettype wire
